// File: rtl/serial_paralelo.sv
// Receive-side serial-to-parallel converter.
// Assembles MSB-first serial bits into bytes, acquires sync on a run of COM
// characters, then distributes data bytes round-robin onto four 8-bit lanes.
module serial_paralelo #(
    parameter logic [7:0]  COM     = 8'hBC,
    parameter int unsigned SYNC_BC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out0,
    output logic [7:0] data_out1,
    output logic [7:0] data_out2,
    output logic [7:0] data_out3,
    output logic       valid_out0,
    output logic       valid_out1,
    output logic       valid_out2,
    output logic       valid_out3,
    output logic       active
);

    localparam logic [3:0] SyncBc = 4'(SYNC_BC);

    typedef enum logic [0:0] {
        StSearch,
        StActive
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q;
    // Only the last seven bits are kept; the eighth comes straight from data_in.
    logic [6:0]  shift_q;
    logic [3:0]  bc_cnt_q, bc_cnt_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  hold_q [4];
    logic [7:0]  hold_d [4];
    logic [7:0]  data_q [4];
    logic [7:0]  data_d [4];
    logic [3:0]  valid_q, valid_d;
    logic        active_q, active_d;

    logic        byte_done;
    logic [7:0]  new_byte;

    assign byte_done = (bit_cnt_q == 3'd7);
    assign new_byte  = {shift_q, data_in};

    // Bit counter and shift register: free-running, alignment fixed by reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
        end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            shift_q   <= {shift_q[5:0], data_in};
        end
    end

    // State, counters, holding registers and registered lane outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StSearch;
            bc_cnt_q <= 4'd0;
            ptr_q    <= 2'd0;
            valid_q  <= 4'd0;
            active_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= 8'd0;
                data_q[i] <= 8'd0;
            end
        end else begin
            state_q  <= state_d;
            bc_cnt_q <= bc_cnt_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            active_q <= active_d;
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= hold_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    // Next-state: sync acquisition in SEARCH, lane distribution and flush in ACTIVE.
    always_comb begin
        state_d  = state_q;
        bc_cnt_d = bc_cnt_q;
        ptr_d    = ptr_q;
        active_d = active_q;
        valid_d  = 4'd0;  // valids are single-cycle pulses
        for (int i = 0; i < 4; i++) begin
            hold_d[i] = hold_q[i];
            data_d[i] = data_q[i];
        end

        if (byte_done) begin
            unique case (state_q)
                StSearch: begin
                    if (new_byte == COM) begin
                        bc_cnt_d = bc_cnt_q + 4'd1;
                        if ((bc_cnt_q + 4'd1) == SyncBc) begin
                            state_d  = StActive;
                            active_d = 1'b1;
                        end
                    end else begin
                        bc_cnt_d = 4'd0;
                    end
                end
                StActive: begin
                    if (new_byte != COM) begin
                        hold_d[ptr_q] = new_byte;
                        ptr_d         = ptr_q + 2'd1;
                        if (ptr_q == 2'd3) begin
                            data_d[0] = hold_q[0];
                            data_d[1] = hold_q[1];
                            data_d[2] = hold_q[2];
                            data_d[3] = new_byte;
                            valid_d   = 4'b1111;
                        end
                    end else if (ptr_q != 2'd0) begin
                        // COM mid-word flushes the partial word; unused lanes are zeroed.
                        for (int i = 0; i < 4; i++) begin
                            if (2'(i) < ptr_q) begin
                                data_d[i]  = hold_q[i];
                                valid_d[i] = 1'b1;
                            end else begin
                                data_d[i]  = 8'd0;
                            end
                        end
                        ptr_d = 2'd0;
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    assign data_out0  = data_q[0];
    assign data_out1  = data_q[1];
    assign data_out2  = data_q[2];
    assign data_out3  = data_q[3];
    assign valid_out0 = valid_q[0];
    assign valid_out1 = valid_q[1];
    assign valid_out2 = valid_q[2];
    assign valid_out3 = valid_q[3];
    assign active     = active_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Self-checking bench for serial_paralelo: byte-level vector table plus
// hand-written sequences for sync interruption and reset corner cases.
module tb_serial_paralelo;

    logic       clk;
    logic       reset;
    logic       data_in;
    logic [7:0] d0, d1, d2, d3;
    logic       v0, v1, v2, v3;
    logic       act;

    int tests;
    int fails;

    serial_paralelo #(
        .COM     (8'hBC),
        .SYNC_BC (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_out0  (d0),
        .data_out1  (d1),
        .data_out2  (d2),
        .data_out3  (d3),
        .valid_out0 (v0),
        .valid_out1 (v1),
        .valid_out2 (v2),
        .valid_out3 (v3),
        .active     (act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  din;
        logic [31:0] dout;  // {lane0, lane1, lane2, lane3}
        logic [3:0]  vld;   // {v0, v1, v2, v3}
        logic        act;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one bit, let the rising edge sample it, then settle away from the edge.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    function automatic logic [31:0] dout_w();
        return {d0, d1, d2, d3};
    endfunction

    function automatic logic [3:0] vld_w();
        return {v0, v1, v2, v3};
    endfunction

    // Hold reset a few cycles and release #1 after an edge, so the next edge is edge 0.
    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic sync4();
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] seq_b [8];
        logic       seq_a [8];
        logic       saw_valid;

        tests   = 0;
        fails   = 0;
        reset   = 1'b0;
        data_in = 1'b0;

        tbl[0]  = '{8'hBC, 32'h00000000, 4'b0000, 1'b0};
        tbl[1]  = '{8'hBC, 32'h00000000, 4'b0000, 1'b0};
        tbl[2]  = '{8'hBC, 32'h00000000, 4'b0000, 1'b0};
        tbl[3]  = '{8'hBC, 32'h00000000, 4'b0000, 1'b1};
        tbl[4]  = '{8'h01, 32'h00000000, 4'b0000, 1'b1};
        tbl[5]  = '{8'h02, 32'h00000000, 4'b0000, 1'b1};
        tbl[6]  = '{8'h03, 32'h00000000, 4'b0000, 1'b1};
        tbl[7]  = '{8'h04, 32'h01020304, 4'b1111, 1'b1};
        tbl[8]  = '{8'hBC, 32'h01020304, 4'b0000, 1'b1};
        tbl[9]  = '{8'hBC, 32'h01020304, 4'b0000, 1'b1};
        tbl[10] = '{8'hAA, 32'h01020304, 4'b0000, 1'b1};
        tbl[11] = '{8'h55, 32'h01020304, 4'b0000, 1'b1};
        tbl[12] = '{8'hBC, 32'hAA550000, 4'b1100, 1'b1};
        tbl[13] = '{8'h10, 32'hAA550000, 4'b0000, 1'b1};
        tbl[14] = '{8'h11, 32'hAA550000, 4'b0000, 1'b1};
        tbl[15] = '{8'h12, 32'hAA550000, 4'b0000, 1'b1};
        tbl[16] = '{8'h13, 32'h10111213, 4'b1111, 1'b1};
        tbl[17] = '{8'h14, 32'h10111213, 4'b0000, 1'b1};
        tbl[18] = '{8'h15, 32'h10111213, 4'b0000, 1'b1};
        tbl[19] = '{8'h16, 32'h10111213, 4'b0000, 1'b1};
        tbl[20] = '{8'h17, 32'h14151617, 4'b1111, 1'b1};
        tbl[21] = '{8'hEE, 32'h14151617, 4'b0000, 1'b1};

        // Reset held with random serial data: everything stays at zero.
        for (int i = 0; i < 20; i++) begin
            data_in = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        check("rst_dout", dout_w(), 32'h0);
        check("rst_vld", {28'h0, vld_w()}, 32'h0);
        check("rst_act", {31'h0, act}, 32'h0);
        reset = 1'b1;

        // Vector table: sync, full word, idle filler, flush, back-to-back words.
        for (int i = 0; i < 22; i++) begin
            send_bit(tbl[i].din[7]);
            if (i > 0) begin
                // One cycle after any completion the pulse must be gone and data held.
                check($sformatf("vld_drop[%0d]", i), {28'h0, vld_w()}, 32'h0);
                check($sformatf("hold[%0d]", i), dout_w(), tbl[i-1].dout);
            end
            for (int b = 6; b >= 0; b--) send_bit(tbl[i].din[b]);
            check($sformatf("dout[%0d]", i), dout_w(), tbl[i].dout);
            check($sformatf("vld[%0d]", i), {28'h0, vld_w()}, {28'h0, tbl[i].vld});
            check($sformatf("act[%0d]", i), {31'h0, act}, {31'h0, tbl[i].act});
        end

        // Asynchronous reset between edges clears outputs without waiting for a clock.
        #2;
        reset = 1'b0;
        #1;
        check("async_dout", dout_w(), 32'h0);
        check("async_act", {31'h0, act}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Interrupted COM run: sync only after four consecutive COMs.
        seq_b = '{8'hBC, 8'hBC, 8'hBC, 8'h12, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
        seq_a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            send_byte(seq_b[i]);
            check($sformatf("resync_act[%0d]", i), {31'h0, act}, {31'h0, seq_a[i]});
        end
        check("resync_vld", {28'h0, vld_w()}, 32'h0);

        // Reset mid-word: partial word dropped, no pulse, sync must be re-acquired.
        do_reset();
        sync4();
        send_byte(8'h10);
        send_byte(8'h11);
        send_bit(1'b0);
        send_bit(1'b1);
        saw_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            data_in = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (vld_w() != 4'b0) saw_valid = 1'b1;
        end
        check("midrst_act", {31'h0, act}, 32'h0);
        check("midrst_dout", dout_w(), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h20 + 8'(i));
            if (vld_w() != 4'b0) saw_valid = 1'b1;
        end
        check("midrst_nopulse", {31'h0, saw_valid}, 32'h0);
        check("midrst_still_search", {31'h0, act}, 32'h0);
        sync4();
        check("midrst_resync", {31'h0, act}, 32'h1);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        send_byte(8'hA4);
        check("midrst_word", dout_w(), 32'hA1A2A3A4);
        check("midrst_word_vld", {28'h0, vld_w()}, 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_paralelo.md
# serial_paralelo

Receive-side serial-to-parallel converter feeding the recirculator stage. Assembles a 1-bit serial stream into bytes, acquires synchronisation by counting consecutive COM (8'hBC) idle bytes, then asserts `active` and distributes data bytes round-robin onto four 8-bit lanes with per-lane valid. Its `data_out0..3`, `valid_out0..3` and `active` outputs connect directly to the recirculator's `data_in0..3`, `valid0..3` and `active` inputs.

## Interface
- `COM` default 8'hBC: idle/sync character.
- `SYNC_BC` default 4: consecutive COM bytes needed to enter ACTIVE; range 1..15.
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-low reset; forces every register to its reset value immediately while low.
- `data_in` input 1: serial data, MSB first, sampled every rising edge.
- `data_out0..data_out3` output 8 each: lane bytes, registered.
- `valid_out0..valid_out3` output 1 each: lane valid, registered, one-cycle pulse.
- `active` output 1: link synchronised, registered.

## Operation
- Reset values: all `data_out*` = 0, all `valid_out*` = 0, `active` = 0; state SEARCH, bit counter 0, shift register 0, bc counter 0, lane pointer 0, lane holding registers 0.
- Shift: `shift <= {shift[6:0], data_in}` every edge. 3-bit bit counter free-runs 0..7 from reset release, wraps 7→0.
- Byte completion: on the edge where bit counter == 7; completed byte = `{shift[6:0], data_in}`. Byte alignment is fixed by reset release; no sliding-window search.
- State SEARCH (`active` = 0): on each completed byte: COM → bc counter +1; non-COM → bc counter 0. When the increment makes bc counter == SYNC_BC → ACTIVE, `active` <= 1 on that same edge. No lane outputs generated in SEARCH.
- State ACTIVE (`active` = 1): stays until reset; no loss-of-sync exit.
  - Completed non-COM byte: written to holding register [lane pointer], pointer +1 (2-bit). If pointer was 3: `data_out0..3` <= holding 0..2 plus the new byte, `valid_out0..3` <= 1, pointer → 0.
  - Completed COM byte with pointer == 0: ignored (idle filler), no output.
  - Completed COM byte with pointer == p ≠ 0 (flush): `data_out0..p-1` <= holding 0..p-1, `valid_out0..p-1` <= 1, `valid_out p..3` <= 0, `data_out p..3` <= 0, pointer → 0.
- `valid_out*` default to 0 on every edge not performing an output update (pulse, not level). `data_out*` hold last value between updates.
- Reset asserted mid-byte/mid-word: partial byte and partial word discarded, no output pulse; after release, sync must be re-acquired from SEARCH.

## Timing
- Edge 0 = first rising edge with `reset` high. Byte k completes at edge 8k+7.
- `active` rises in the cycle after the edge completing the SYNC_BC-th consecutive COM (SYNC_BC=4, bytes 0..3 COM: high after edge 31).
- Lane latency: outputs/valids visible the cycle after the edge completing the 4th data byte (or the flushing COM); valid high exactly one cycle.
- Maximum output rate: one word every 32 cycles. Throughput never stalls; no backpressure.

## Test plan
- Reset: hold `reset` low with random `data_in` for 20 cycles, then assert low asynchronously between edges → all outputs 0 immediately, `active` 0.
- Sync acquisition: BC,BC,BC,BC from edge 0 → `active` 1 after edge 31; BC,BC,BC,12,BC,BC,BC,BC → `active` 1 only after edge 63.
- Full word: sync, then 01,02,03,04 → after edge 63 `data_out0..3` = 01,02,03,04, all valids 1 for one cycle, then 0 with data held.
- Idle filler and flush: after sync, BC,BC,AA,55,BC → no output for leading BCs; after flushing BC, `data_out0`=AA, `data_out1`=55, `valid_out0..1`=1, `valid_out2..3`=0, `data_out2..3`=00.
- Back-to-back: 8 data bytes 10..17 after sync → two pulses 32 cycles apart, lanes 10..13 then 14..17.
- Reset mid-word: after 10,11 in ACTIVE, pulse `reset` low → no valid pulse, `active` 0; resync required before new output.
